// File: rtl/tkm_serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed overflow output is enabled by TKM_SUB_OVF_EN.
package tkm_sub_pkg;

    localparam int TKM_SUB_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } sub_state_t;

    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/tkm_serial_sub_if.sv
// Operand/result bundle for tkm_serial_sub.
// ovf_o exists only when TKM_SUB_OVF_EN is defined.
interface tkm_serial_sub_if
    import tkm_sub_pkg::*;
#(
    parameter int WIDTH = TKM_SUB_WIDTH
);

    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
`ifdef TKM_SUB_OVF_EN
    logic             ovf_o;

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, diff_o, borrow_o, ovf_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, diff_o, borrow_o, ovf_o
    );
`else
    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, diff_o, borrow_o
    );

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, diff_o, borrow_o
    );
`endif

endinterface

// File: rtl/tkm_serial_sub_full_sub.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
module tkm_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tkm_serial_sub.sv
// Bit-serial subtractor: a - b computed LSB-first, one bit per clock.
// Define TKM_SUB_OVF_EN to add the registered signed-overflow output ovf_o.
module tkm_serial_sub
    import tkm_sub_pkg::*;
#(
    parameter int WIDTH = TKM_SUB_WIDTH
) (
    input logic             clk,
    input logic             rst,
    tkm_serial_sub_if.slave bus
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] part;
    logic             bin_q;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;
`ifdef TKM_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
    logic             ovf_q;
`endif

    tkm_full_sub u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Partial result keeps only WIDTH-1 bits; the last bit is taken straight
    // from the cell on the completion edge.
    assign res_next = {d_bit, part};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            part     <= '0;
            bin_q    <= 1'b0;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef TKM_SUB_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start_i) begin
                        a_sr   <= bus.a_i;
                        b_sr   <= bus.b_i;
                        part   <= '0;
                        bin_q  <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= SHIFT;
`ifdef TKM_SUB_OVF_EN
                        a_msb  <= bus.a_i[WIDTH-1];
                        b_msb  <= bus.b_i[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    part  <= res_next[WIDTH-1:1];
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    bin_q <= bout_bit;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_q   <= res_next;
                        borrow_q <= bout_bit;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        cnt      <= '0;
                        state    <= DONE;
`ifdef TKM_SUB_OVF_EN
                        ovf_q    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.diff_o   = diff_q;
    assign bus.borrow_o = borrow_q;
`ifdef TKM_SUB_OVF_EN
    assign bus.ovf_o    = ovf_q;
`endif

endmodule

// File: tb/tb_tkm_serial_sub.sv
// Self-checking bench for tkm_serial_sub (WIDTH=8); checks ovf_o when TKM_SUB_OVF_EN is defined.
module tb_tkm_serial_sub;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [W-1:0] last_diff = '0;
    logic         last_borrow = 1'b0;

    tkm_serial_sub_if #(.WIDTH(W)) bus ();

    tkm_serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output logic br, output logic ov);
        int ua;
        int ub;
        int sd;
        ua = int'(a);
        ub = int'(b);
        d  = W'((ua - ub + (1 << W)) % (1 << W));
        br = (ua < ub);
        sd = int'($signed(a)) - int'($signed(b));
        ov = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        model(a, b, ed, eb, eo);
        chk({tag, "_diff"}, 32'(bus.diff_o), 32'(ed));
        chk({tag, "_borrow"}, 32'(bus.borrow_o), 32'(eb));
`ifdef TKM_SUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf_o), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected X in reference model");
`endif
        last_diff   = ed;
        last_borrow = eb;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat;
        logic held;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        chk({tag, "_busy_after_start"}, 32'(bus.busy_o), 32'd1);
        chk({tag, "_done_after_start"}, 32'(bus.done_o), 32'd0);
        lat  = 0;
        held = 1'b1;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            if (bus.diff_o !== last_diff || bus.borrow_o !== last_borrow || bus.busy_o !== 1'b1)
                held = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        chk({tag, "_hold_in_shift"}, 32'(held), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(bus.busy_o), 32'd0);
        check_result(tag, a, b);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;

        vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'h01, diff: 8'h7E, borrow: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};

        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_diff", 32'(bus.diff_o), 32'd0);
        chk("rst_borrow", 32'(bus.borrow_o), 32'd0);
`ifdef TKM_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Table: each op starts from DONE of the previous one (back-to-back).
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_tbl_diff", i), 32'(bus.diff_o), 32'(vecs[i].diff));
            chk($sformatf("vec%0d_tbl_borrow", i), 32'(bus.borrow_o), 32'(vecs[i].borrow));
`ifdef TKM_SUB_OVF_EN
            chk($sformatf("vec%0d_tbl_ovf", i), 32'(bus.ovf_o), 32'(vecs[i].ovf));
`endif
        end

        // Start held through SHIFT with changing operands.
        begin
            logic [W-1:0] ha;
            logic [W-1:0] hb;
            ha = 8'hA5;
            hb = 8'h3C;
            @(negedge clk);
            bus.start_i = 1'b1;
            bus.a_i     = ha;
            bus.b_i     = hb;
            @(posedge clk);
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                bus.a_i = W'($urandom);
                bus.b_i = W'($urandom);
                @(posedge clk);
            end
            #1;
            chk("held_done", 32'(bus.done_o), 32'd1);
            check_result("held", ha, hb);
            @(negedge clk) bus.start_i = 1'b0;
            @(posedge clk);
            #1;
            chk("held_no_restart", 32'(bus.done_o), 32'd1);
            chk("held_diff_stable", 32'(bus.diff_o), 32'(last_diff));
        end

        // Reset on the 4th SHIFT edge of 0x10 - 0x01.
        run_op("pre_rst", 8'h05, 8'h03);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 8'h10;
        bus.b_i     = 8'h01;
        @(posedge clk);
        @(negedge clk) bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_done", 32'(bus.done_o), 32'd0);
        chk("abort_diff", 32'(bus.diff_o), 32'd0);
        chk("abort_borrow", 32'(bus.borrow_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_abort_idle_busy", 32'(bus.busy_o), 32'd0);
        chk("post_abort_idle_done", 32'(bus.done_o), 32'd0);
        last_diff   = '0;
        last_borrow = 1'b0;
        run_op("fresh", 8'h10, 8'h01);
        chk("fresh_0f", 32'(bus.diff_o), 32'h0F);

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
